mux2_arbiter: RTL and testbench

Round-robin arbiter that shares one MUX2x1 datapath between two requesters, A and B. It drives the mux select and per-requester grants, and hands the path over on transaction boundaries. A per-grant beat cap (MAX_BEATS) stops either side from holding the path indefinitely. It sits between two producer units (e.g. ALU result and load data) and the shared write-back path.

---
 rtl/mux2_arbiter.sv | 116 +++++++++++
 tb/tb_mux2_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one 2:1 write-back mux between requesters A and B.
// Ownership changes only on transaction boundaries or when the per-grant beat cap is reached.
module mux2_arbiter #(
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic last_a,
  input  logic req_b,
  input  logic last_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic out_valid,
  output logic busy
);

  if (MAX_BEATS < 1 || MAX_BEATS > (2 ** CNT_W)) begin : g_bad_param
    $error("mux2_arbiter: MAX_BEATS-1 must fit in CNT_W bits and MAX_BEATS >= 1");
  end

  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_last_a;
  logic             w_last_a_nxt;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_sel;
  logic             r_busy;
  logic             w_cap;

  assign w_cap = (r_cnt == CAP);

  // An abandoned grant (req dropped) releases without counting a beat.
  always_comb begin
    w_nxt        = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_a_nxt = r_last_a;
    case (r_state)
      IDLE: begin
        if (req_a && req_b)
          w_nxt = r_last_a ? GRANT_B : GRANT_A;
        else if (req_a)
          w_nxt = GRANT_A;
        else if (req_b)
          w_nxt = GRANT_B;
      end
      GRANT_A: begin
        if (!req_a || last_a || w_cap) begin
          w_cnt_nxt    = '0;
          w_last_a_nxt = 1'b1;
          w_nxt        = req_b ? GRANT_B : IDLE;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      GRANT_B: begin
        if (!req_b || last_b || w_cap) begin
          w_cnt_nxt    = '0;
          w_last_a_nxt = 1'b0;
          w_nxt        = req_a ? GRANT_A : IDLE;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: begin
        w_nxt     = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are registered decodes of the next state; sel keeps its value through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last_a <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last_a <= w_last_a_nxt;
      r_gnt_a  <= (w_nxt == GRANT_A);
      r_gnt_b  <= (w_nxt == GRANT_B);
      r_busy   <= (w_nxt != IDLE);
      if (w_nxt == GRANT_A)
        r_sel <= 1'b1;
      else if (w_nxt == GRANT_B)
        r_sel <= 1'b0;
    end
  end

  assign gnt_a     = r_gnt_a;
  assign gnt_b     = r_gnt_b;
  assign sel       = r_sel;
  assign busy      = r_busy;
  assign out_valid = (r_gnt_a & req_a) | (r_gnt_b & req_b);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares. Second instance runs with MAX_BEATS = 1.
module tb_mux2_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic ra0, la0, rb0, lb0;
  logic ga0, gb0, sel0, ov0, busy0;
  logic ra1, la1, rb1, lb1;
  logic ga1, gb1, sel1, ov1, busy1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit         id;
    logic [4:0] exp;  // {gnt_a, gnt_b, sel, busy, out_valid}
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   vec_no = 0;

  always #5 clk = ~clk;

  mux2_arbiter #(.MAX_BEATS(4), .CNT_W(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_a(ra0), .last_a(la0), .req_b(rb0), .last_b(lb0),
    .gnt_a(ga0), .gnt_b(gb0), .sel(sel0), .out_valid(ov0), .busy(busy0)
  );

  mux2_arbiter #(.MAX_BEATS(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_a(ra1), .last_a(la1), .req_b(rb1), .last_b(lb1),
    .gnt_a(ga1), .gnt_b(gb1), .sel(sel1), .out_valid(ov1), .busy(busy1)
  );

  // Monitor: every negedge with pending expectations, compare one cycle's outputs.
  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.id ? {ga1, gb1, sel1, busy1, ov1} : {ga0, gb0, sel0, busy0, ov0};
      n_chk++;
      if (act === e.exp) n_pass++;
      else $display("FAIL vec%0d dut%0d {gnt_a,gnt_b,sel,busy,out_valid}: got %b expected %b",
                    e.tag, e.id, act, e.exp);
      n_chk++;
      if (((ga0 & gb0) | (ga1 & gb1)) === 1'b0) n_pass++;
      else $display("FAIL vec%0d grant_overlap: got 1 expected 0", e.tag);
    end
  end

  // Apply one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input bit id, input logic [3:0] in, input logic [4:0] exp);
    exp_t e;
    if (id) begin
      {ra1, la1, rb1, lb1} = in;
      {ra0, la0, rb0, lb0} = 4'b0000;
    end else begin
      {ra0, la0, rb0, lb0} = in;
      {ra1, la1, rb1, lb1} = 4'b0000;
    end
    e.id  = id;
    e.exp = exp;
    e.tag = vec_no;
    vec_no++;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset_and_check(input int tag);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ga0, gb0, sel0, busy0, ov0} === 5'b00000) n_pass++;
    else $display("FAIL async_reset%0d: got %b expected 00000", tag,
                  {ga0, gb0, sel0, busy0, ov0});
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {ra0, la0, rb0, lb0} = 4'b0000;
    {ra1, la1, rb1, lb1} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // inputs {req_a,last_a,req_b,last_b}; expected {gnt_a,gnt_b,sel,busy,out_valid}
    // Reset state, then A alone with last on beat 3
    step(0, 4'b0000, 5'b00000);
    step(0, 4'b1000, 5'b00000);
    step(0, 4'b1000, 5'b10111);
    step(0, 4'b1000, 5'b10111);
    step(0, 4'b1100, 5'b10111);
    step(0, 4'b0000, 5'b00100);
    step(0, 4'b0000, 5'b00100);

    // Both held from reset: A 4 beats, B 4 beats without bubble, then A
    pulse_reset_and_check(0);
    step(0, 4'b1010, 5'b00000);
    repeat (4) step(0, 4'b1010, 5'b10111);
    repeat (4) step(0, 4'b1010, 5'b01011);
    repeat (2) step(0, 4'b1010, 5'b10111);
    step(0, 4'b0000, 5'b10110);
    step(0, 4'b0000, 5'b00100);

    // last_a on beat 2 while B waits: same-edge handover, sel 1 -> 0
    step(0, 4'b1000, 5'b00100);
    step(0, 4'b1000, 5'b10111);
    step(0, 4'b1110, 5'b10111);
    step(0, 4'b0011, 5'b01011);
    step(0, 4'b0100, 5'b00000);

    // Abandon after 1 beat: IDLE with sel held; counter cleared so next grant gets 4 beats
    step(0, 4'b1000, 5'b00000);
    step(0, 4'b1000, 5'b10111);
    step(0, 4'b0000, 5'b10110);
    step(0, 4'b0000, 5'b00100);
    step(0, 4'b1000, 5'b00100);
    repeat (4) step(0, 4'b1000, 5'b10111);
    step(0, 4'b1000, 5'b00100);
    step(0, 4'b0000, 5'b10110);
    step(0, 4'b0000, 5'b00100);

    // Async reset mid-transaction; first tie afterwards goes to A
    step(0, 4'b1000, 5'b00100);
    step(0, 4'b1000, 5'b10111);
    pulse_reset_and_check(1);
    step(0, 4'b1010, 5'b00000);
    step(0, 4'b1010, 5'b10111);
    step(0, 4'b0000, 5'b10110);
    step(0, 4'b0000, 5'b00100);

    // MAX_BEATS = 1 with only B: grant alternates with an IDLE bubble
    step(1, 4'b0010, 5'b00000);
    step(1, 4'b0010, 5'b01011);
    step(1, 4'b0010, 5'b00000);
    step(1, 4'b0010, 5'b01011);
    step(1, 4'b0010, 5'b00000);
    step(1, 4'b0000, 5'b01010);
    step(1, 4'b0000, 5'b00000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
